// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 inverse cipher.
package aes_pkg;

  localparam int NR    = 10;
  localparam int BLK_W = 128;
  localparam int KS_W  = BLK_W * (NR + 1);

  typedef logic [0:BLK_W-1] state_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_KEY = 3'd1,
    ROUND    = 3'd2,
    FINAL    = 3'd3,
    DONE     = 3'd4
  } fsm_t;

  typedef enum logic [1:0] {
    OP_ADDKEY   = 2'd0,
    OP_INVSHIFT = 2'd1,
    OP_INVSUB   = 2'd2,
    OP_INVMIX   = 2'd3
  } op_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? sh : 8'h00);
      sh  = xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as b^254 (squares b^2..b^128 accumulated); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y;
    y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

endpackage

// File: rtl/aes_inv_round_datapath.sv
// Combinational inverse-round step: applies the selected AES operation to the state.
module aes_inv_round_datapath
  import aes_pkg::*;
(
  input  state_t state,
  input  op_t    op,
  input  state_t round_key,
  output state_t next_state
);

  state_t shift_s;
  state_t sub_s;
  state_t mix_s;

  // Byte index is row + 4*column; row r rotates right by r columns.
  always_comb begin
    shift_s = state;
    sub_s   = state;
    mix_s   = state;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_s[8*(r+4*c) +: 8] = state[8*(r+4*((c+4-r)%4)) +: 8];
        sub_s[8*(r+4*c) +: 8]   = inv_sbox(state[8*(r+4*c) +: 8]);
        mix_s[8*(r+4*c) +: 8]   = gf_mul(state[8*(4*c+r) +: 8],         8'h0e)
                                ^ gf_mul(state[8*(4*c+(r+1)%4) +: 8], 8'h0b)
                                ^ gf_mul(state[8*(4*c+(r+2)%4) +: 8], 8'h0d)
                                ^ gf_mul(state[8*(4*c+(r+3)%4) +: 8], 8'h09);
      end
    end
  end

  // Select the result of the operation executing this cycle.
  always_comb begin
    next_state = state;
    case (op)
      OP_ADDKEY:   next_state = state ^ round_key;
      OP_INVSHIFT: next_state = shift_s;
      OP_INVSUB:   next_state = sub_s;
      OP_INVMIX:   next_state = mix_s;
      default:     next_state = state;
    endcase
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// AES-128 inverse-cipher sequencer: one inverse-round operation per clock, 41-cycle latency.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [0:BLK_W-1] ciphertext,
  input  logic [0:KS_W-1]  key_schedule,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [0:BLK_W-1] plaintext,
  output logic [3:0]       dbg_round,
  output logic [1:0]       dbg_op
);

  fsm_t       state_r;
  fsm_t       state_next_s;
  op_t        op_r;
  op_t        op_next_s;
  logic [3:0] round_r;
  logic [3:0] round_next_s;
  state_t     blk_r;
  state_t     blk_next_s;
  state_t     pt_next_s;
  state_t     rk_s;
  state_t     dp_out_s;
  logic       accept_s;
  logic       done_next_s;
  logic       ready_next_s;
  logic       busy_next_s;
  logic [3:0] dbg_round_next_s;
  logic [1:0] dbg_op_next_s;

  assign accept_s = start & ready;

  // Round-key index mux; out-of-range indices fall back to the first key.
  always_comb begin
    case (round_r)
      4'd0:    rk_s = key_schedule[0*BLK_W +: BLK_W];
      4'd1:    rk_s = key_schedule[1*BLK_W +: BLK_W];
      4'd2:    rk_s = key_schedule[2*BLK_W +: BLK_W];
      4'd3:    rk_s = key_schedule[3*BLK_W +: BLK_W];
      4'd4:    rk_s = key_schedule[4*BLK_W +: BLK_W];
      4'd5:    rk_s = key_schedule[5*BLK_W +: BLK_W];
      4'd6:    rk_s = key_schedule[6*BLK_W +: BLK_W];
      4'd7:    rk_s = key_schedule[7*BLK_W +: BLK_W];
      4'd8:    rk_s = key_schedule[8*BLK_W +: BLK_W];
      4'd9:    rk_s = key_schedule[9*BLK_W +: BLK_W];
      4'd10:   rk_s = key_schedule[10*BLK_W +: BLK_W];
      default: rk_s = key_schedule[0*BLK_W +: BLK_W];
    endcase
  end

  aes_inv_round_datapath u_datapath (
    .state      (blk_r),
    .op         (op_r),
    .round_key  (rk_s),
    .next_state (dp_out_s)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_next_s = state_r;
    op_next_s    = op_r;
    round_next_s = round_r;
    blk_next_s   = blk_r;
    pt_next_s    = plaintext;
    done_next_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          blk_next_s   = ciphertext;
          round_next_s = 4'(NR);
          op_next_s    = OP_ADDKEY;
          state_next_s = INIT_KEY;
        end else begin
          round_next_s = 4'd0;
          op_next_s    = OP_ADDKEY;
          state_next_s = IDLE;
        end
      end
      INIT_KEY: begin
        blk_next_s   = dp_out_s;
        round_next_s = round_r - 4'd1;
        op_next_s    = OP_INVSHIFT;
        state_next_s = ROUND;
      end
      ROUND: begin
        blk_next_s = dp_out_s;
        case (op_r)
          OP_INVSHIFT: op_next_s = OP_INVSUB;
          OP_INVSUB:   op_next_s = OP_ADDKEY;
          OP_ADDKEY:   op_next_s = OP_INVMIX;
          OP_INVMIX: begin
            op_next_s    = OP_INVSHIFT;
            round_next_s = round_r - 4'd1;
            if (round_r == 4'd1) begin
              state_next_s = FINAL;
            end else begin
              state_next_s = ROUND;
            end
          end
          default: op_next_s = OP_INVSHIFT;
        endcase
      end
      FINAL: begin
        blk_next_s = dp_out_s;
        case (op_r)
          OP_INVSHIFT: op_next_s = OP_INVSUB;
          OP_INVSUB:   op_next_s = OP_ADDKEY;
          OP_ADDKEY: begin
            pt_next_s    = dp_out_s;
            done_next_s  = 1'b1;
            op_next_s    = OP_ADDKEY;
            round_next_s = 4'd0;
            state_next_s = DONE;
          end
          default: state_next_s = IDLE;
        endcase
      end
      default: state_next_s = IDLE;
    endcase
    ready_next_s     = (state_next_s == IDLE) || (state_next_s == DONE);
    busy_next_s      = ~ready_next_s;
    dbg_round_next_s = busy_next_s ? round_next_s : 4'd0;
    dbg_op_next_s    = busy_next_s ? op_next_s : 2'd0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      op_r      <= OP_ADDKEY;
      round_r   <= 4'd0;
      blk_r     <= '0;
      plaintext <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbg_round <= 4'd0;
      dbg_op    <= 2'd0;
    end else begin
      state_r   <= state_next_s;
      op_r      <= op_next_s;
      round_r   <= round_next_s;
      blk_r     <= blk_next_s;
      plaintext <= pt_next_s;
      ready     <= ready_next_s;
      busy      <= busy_next_s;
      done      <= done_next_s;
      dbg_round <= dbg_round_next_s;
      dbg_op    <= dbg_op_next_s;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: forward AES-128 reference model, known vectors and random round trips.
module tb_aes_inv_cipher_ctrl;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic [0:127]  ciphertext = '0;
  logic [0:1407] key_schedule = '0;
  logic          ready;
  logic          busy;
  logic          done;
  logic [0:127]  plaintext;
  logic [3:0]    dbg_round;
  logic [1:0]    dbg_op;

  int errors = 0;
  int checks = 0;
  logic [7:0] sbox_t [256];

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 Clk = ~Clk;

  aes_inv_cipher_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .ciphertext   (ciphertext),
    .key_schedule (key_schedule),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .plaintext    (plaintext),
    .dbg_round    (dbg_round),
    .dbg_op       (dbg_op)
  );

  // ---------------- reference model (forward AES-128) ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (m_mul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:1407] key_expand(input logic [0:127] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h000000};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1407] ks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ks[8*i +: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*rnd + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
    return o;
  endfunction

  // Drive one block and wait (bounded) for done; no checking here.
  task automatic launch(input logic [0:127] ct, output int cycles, output logic [0:127] pt,
                        output logic ok);
    ciphertext = ct;
    start      = 1'b1;
    cycles     = 0;
    ok         = 1'b0;
    pt         = '0;
    while (!ok && cycles < 200) begin
      @(posedge Clk); #1;
      cycles++;
      if (cycles == 1) start = 1'b0;
      if (done) begin
        ok = 1'b1;
        pt = plaintext;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({ready, busy, done, dbg_round, dbg_op, plaintext} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b busy=%b done=%b round=%0d op=%0d pt=%h, want all 0",
               ready, busy, done, dbg_round, dbg_op, plaintext);
    end
    Reset = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if ({ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b, want ready=1 busy=0", ready, busy);
    end
  endtask

  task automatic test_fips_c1();
    int cyc;
    logic [0:127] pt;
    logic ok;
    key_schedule = key_expand(C1_KEY);
    launch(C1_CT, cyc, pt, ok);
    checks++;
    if (!ok || cyc != 41) begin
      errors++;
      $display("FAIL c1_latency: got ok=%b cycles=%0d, want done after 41", ok, cyc);
    end
    checks++;
    if (pt !== C1_PT) begin
      errors++;
      $display("FAIL c1_plaintext: got %h, want %h", pt, C1_PT);
    end
    checks++;
    if ({ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL c1_done_flags: got ready=%b busy=%b, want 1/0", ready, busy);
    end
    @(posedge Clk); #1;
    checks++;
    if ({done, ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL c1_pulse: got done=%b ready=%b busy=%b, want 0/1/0", done, ready, busy);
    end
  endtask

  task automatic test_fips_b_trace(input logic [0:127] held_pt);
    logic [3:0] exp_r [40];
    logic [1:0] exp_o [40];
    int n;
    exp_r[0] = 4'd10; exp_o[0] = 2'd0;
    n = 1;
    for (int r = 9; r >= 1; r--) begin
      exp_r[n] = 4'(r); exp_o[n] = 2'd1; n++;
      exp_r[n] = 4'(r); exp_o[n] = 2'd2; n++;
      exp_r[n] = 4'(r); exp_o[n] = 2'd0; n++;
      exp_r[n] = 4'(r); exp_o[n] = 2'd3; n++;
    end
    exp_r[37] = 4'd0; exp_o[37] = 2'd1;
    exp_r[38] = 4'd0; exp_o[38] = 2'd2;
    exp_r[39] = 4'd0; exp_o[39] = 2'd0;
    key_schedule = key_expand(B_KEY);
    ciphertext   = B_CT;
    start        = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (i == 0) start = 1'b0;
      checks++;
      if ({busy, ready, done, dbg_round, dbg_op, plaintext} !==
          {1'b1, 1'b0, 1'b0, exp_r[i], exp_o[i], held_pt}) begin
        errors++;
        $display("FAIL b_trace[%0d]: got busy=%b ready=%b done=%b round=%0d op=%0d pt=%h, want 1/0/0 %0d/%0d pt=%h",
                 i, busy, ready, done, dbg_round, dbg_op, plaintext, exp_r[i], exp_o[i], held_pt);
      end
    end
    @(posedge Clk); #1;
    checks++;
    if ({done, dbg_round, dbg_op, plaintext} !== {1'b1, 4'd0, 2'd0, B_PT}) begin
      errors++;
      $display("FAIL b_result: got done=%b round=%0d op=%0d pt=%h, want done=1 0/0 pt=%h",
               done, dbg_round, dbg_op, plaintext, B_PT);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_random();
    logic [0:127] key;
    logic [0:127] pt_ref;
    logic [0:127] pt;
    int cyc;
    logic ok;
    for (int k = 0; k < 5; k++) begin
      key          = {$urandom, $urandom, $urandom, $urandom};
      pt_ref       = {$urandom, $urandom, $urandom, $urandom};
      key_schedule = key_expand(key);
      launch(encrypt(pt_ref, key_schedule), cyc, pt, ok);
      checks++;
      if (!ok || cyc != 41 || pt !== pt_ref) begin
        errors++;
        $display("FAIL random[%0d]: got ok=%b cycles=%0d pt=%h, want 41 pt=%h", k, ok, cyc, pt, pt_ref);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] key;
    logic [0:127] pt1;
    logic [0:127] pt2;
    logic [0:127] ct2;
    int n;
    int m;
    key          = {$urandom, $urandom, $urandom, $urandom};
    pt1          = {$urandom, $urandom, $urandom, $urandom};
    pt2          = {$urandom, $urandom, $urandom, $urandom};
    key_schedule = key_expand(key);
    ct2          = encrypt(pt2, key_schedule);
    ciphertext   = encrypt(pt1, key_schedule);
    start        = 1'b1;
    @(posedge Clk); #1;
    n = 1;
    ciphertext = ct2;
    while (!done && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    checks++;
    if (!done || n != 41 || plaintext !== pt1) begin
      errors++;
      $display("FAIL b2b_first: got done=%b cycles=%0d pt=%h, want 41 pt=%h", done, n, plaintext, pt1);
    end
    m = 0;
    do begin
      @(posedge Clk); #1;
      m++;
      if (m == 1) begin
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_accept: got busy=%b done=%b, want 1/0", busy, done);
        end
      end
      if (m == 20) begin
        checks++;
        if (plaintext !== pt1) begin
          errors++;
          $display("FAIL b2b_hold_busy: got pt=%h, want %h", plaintext, pt1);
        end
      end
    end while (!done && m < 200);
    checks++;
    if (!done || m != 41 || plaintext !== pt2) begin
      errors++;
      $display("FAIL b2b_second: got done=%b cycles=%0d pt=%h, want 41 pt=%h", done, m, plaintext, pt2);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int bad_done;
    logic [0:127] pt;
    logic ok;
    key_schedule = key_expand(C1_KEY);
    ciphertext   = C1_CT;
    start        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (i == 0) start = 1'b0;
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if ({ready, busy, done, dbg_round, dbg_op, plaintext} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ready=%b busy=%b done=%b round=%0d op=%0d pt=%h, want all 0",
               ready, busy, done, dbg_round, dbg_op, plaintext);
    end
    Reset = 1'b0;
    bad_done = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge Clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) bad_done++;
    end
    checks++;
    if (bad_done != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d cycles with done/busy set or ready low, want 0", bad_done);
    end
    launch(C1_CT, cyc, pt, ok);
    checks++;
    if (!ok || cyc != 41 || pt !== C1_PT) begin
      errors++;
      $display("FAIL midreset_rerun: got ok=%b cycles=%0d pt=%h, want 41 pt=%h", ok, cyc, pt, C1_PT);
    end
  endtask

  task automatic test_idle_hold(input logic [0:127] held_pt);
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #1;
      checks++;
      if ({done, ready, busy, plaintext} !== {1'b0, 1'b1, 1'b0, held_pt}) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got done=%b ready=%b busy=%b pt=%h, want 0/1/0 pt=%h",
                 i, done, ready, busy, plaintext, held_pt);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b_trace(C1_PT);
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_idle_hold(C1_PT);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
